// File: rtl/ws2812_pkg.sv
// WS2812 shared timing, state encoding and pixel type.
// Both the transmitter and the decoder derive timing from here.
package ws2812_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } st_e;

  // Decoder thresholds, in clk cycles
  function automatic int t_thresh(int mhz);
    return mhz * 625 / 1000;
  endfunction

  function automatic int t_high_max(int mhz);
    return mhz * 5;
  endfunction

  function automatic int t_reset_det(int mhz);
    return mhz * 50;
  endfunction

  // Transmitter nominal timing: t_on is the '1' high time,
  // t_off the '0' high time; the low part fills t_period
  function automatic int t_on(int mhz);
    return mhz * 5 / 6;
  endfunction

  function automatic int t_off(int mhz);
    return mhz / 3;
  endfunction

  function automatic int t_period(int mhz);
    return mhz * 4 / 3;
  endfunction

  // Transmitter idles longer than the decoder needs to see a frame end
  function automatic int t_reset(int mhz);
    return mhz * 60;
  endfunction

  localparam int CLK_MHZ_DEF = 12;
  localparam int T_THRESH    = t_thresh(CLK_MHZ_DEF);
  localparam int T_HIGH_MAX  = t_high_max(CLK_MHZ_DEF);
  localparam int T_RESET_DET = t_reset_det(CLK_MHZ_DEF);

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-pixel output bundle of the WS2812 receiver.
// master drives words and frame events, slave consumes them.
interface ws2812_rx_if;
  import ws2812_pkg::*;

  pixel_t     rgb_data;
  logic [7:0] led_num;
  logic       valid;
  logic       frame_done;
  logic       error;

  modport master (
    output rgb_data,
    output led_num,
    output valid,
    output frame_done,
    output error
  );

  modport slave (
    input rgb_data,
    input led_num,
    input valid,
    input frame_done,
    input error
  );

endinterface

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the async data line plus
// a third flop for single-cycle rise/fall detection.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic s1;
  logic din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      s1    <= din;
      din_s <= s1;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: pulse-width bit decode,
// MSB-first 24-bit word assembly and per-frame LED indexing.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_MHZ = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master rx
);

  localparam int TH   = t_thresh(CLK_MHZ);
  localparam int HMAX = t_high_max(CLK_MHZ);
  localparam int RDET = t_reset_det(CLK_MHZ);
  localparam int CW   = $clog2(RDET + 1);

  localparam logic [CW-1:0] TH_C   = CW'(TH);
  localparam logic [CW-1:0] HMAX_C = CW'(HMAX);
  localparam logic [CW-1:0] HSAT_C = CW'(HMAX + 1);
  localparam logic [CW-1:0] RDET_C = CW'(RDET);

  logic din_s;
  logic rise;
  logic fall;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  st_e state;
  st_e next;

  logic [CW-1:0] high_cnt;
  logic [CW-1:0] low_cnt;
  logic [22:0]   shreg;
  logic [4:0]    bit_cnt;
  logic [7:0]    frame_idx;

  pixel_t     rgb_q;
  logic [7:0] led_q;
  logic       valid_q;
  logic       fd_q;
  logic       err_q;

  logic shift;
  logic err_set;
  logic fd_set;
  logic clr;
  logic bit_in;
  logic low_end;

  assign bit_in  = (high_cnt >= TH_C);
  assign low_end = (low_cnt == RDET_C);

  // Level counters; each restarts when the line changes level
  always_ff @(posedge clk) begin
    if (reset) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else if (din_s) begin
      low_cnt <= '0;
      if (high_cnt != HSAT_C)
        high_cnt <= high_cnt + 1'b1;
    end else begin
      high_cnt <= '0;
      if (low_cnt != RDET_C)
        low_cnt <= low_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= SYNC;
    else
      state <= next;
  end

  // A rise on the very cycle the idle count completes
  // must still start a bit, so it is honoured there too
  always_comb begin
    next    = state;
    shift   = 1'b0;
    err_set = 1'b0;
    fd_set  = 1'b0;
    clr     = 1'b0;
    unique case (state)
      SYNC: begin
        clr = 1'b1;
        if (low_end)
          next = rise ? HIGH : IDLE;
      end
      IDLE: begin
        if (rise)
          next = HIGH;
      end
      HIGH: begin
        if (high_cnt > HMAX_C) begin
          err_set = 1'b1;
          clr     = 1'b1;
          next    = SYNC;
        end else if (fall) begin
          shift = 1'b1;
          next  = LOW;
        end
      end
      LOW: begin
        if (low_end) begin
          clr = 1'b1;
          if (bit_cnt == 5'd0)
            fd_set = 1'b1;
          else
            err_set = 1'b1;
          next = rise ? HIGH : IDLE;
        end else if (rise) begin
          next = HIGH;
        end
      end
      default: begin
        clr  = 1'b1;
        next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_idx <= '0;
      rgb_q     <= '0;
      led_q     <= '0;
      valid_q   <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fd_q    <= fd_set;
      err_q   <= err_set;
      if (clr) begin
        bit_cnt   <= '0;
        frame_idx <= '0;
      end else if (shift) begin
        shreg <= {shreg[21:0], bit_in};
        if (bit_cnt == 5'd23) begin
          rgb_q   <= {shreg, bit_in};
          led_q   <= frame_idx;
          valid_q <= 1'b1;
          bit_cnt <= '0;
          if (frame_idx != 8'hFF)
            frame_idx <= frame_idx + 8'd1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  assign rx.rgb_data   = rgb_q;
  assign rx.led_num    = led_q;
  assign rx.valid      = valid_q;
  assign rx.frame_done = fd_q;
  assign rx.error      = err_q;

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Single-wire WS2812 stream decoder, the receive-side counterpart of the team's ws2812 transmitter. It samples an asynchronous data line and classifies each high pulse by its width as a 0 or 1 bit. Bits are assembled MSB-first into 24-bit pixel words, and each word is emitted with a per-frame LED index. Used as an in-system loopback checker for the transmitter and as a front end for chained/bridged LED controllers.

Parameters:
CLK_MHZ, 12, system clock frequency in MHz; all timing derives from it.
T_THRESH, $rtoi($ceil(CLK_MHZ*625/1000)) (=7 at 12 MHz), minimum high-cycle count decoded as '1'.
T_HIGH_MAX, CLK_MHZ*5 (=60), maximum legal high-cycle count; longer is a protocol error.
T_RESET_DET, CLK_MHZ*50 (=600), low-cycle count that marks end of frame / line idle.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  1  asynchronous WS2812 data line
rgb_data  output  24  last decoded pixel word, MSB = first bit received
led_num  output  8  index of rgb_data within the current frame, 0-based
valid  output  1  one-cycle pulse: rgb_data/led_num updated
frame_done  output  1  one-cycle pulse: clean end of frame detected
error  output  1  one-cycle pulse: protocol violation detected

Behaviour:
- Reset and clock: reset is synchronous and active-high; clock is clk.
- On reset: rgb_data=0, led_num=0, valid=0, frame_done=0, error=0, state=SYNC, all counters 0, sync flops 0. Reset mid-word discards the partial word.
- Input path: 2-FF synchronizer gives din_s; a third flop din_d is used for edge detection.
  - rise = din_s & ~din_d
  - fall = ~din_s & din_d
- Counters:
  - high_cnt counts cycles with din_s=1, saturating at T_HIGH_MAX+1.
  - low_cnt counts cycles with din_s=0, saturating at T_RESET_DET.
  - Both clear on the opposite edge.
  - Counter width: $clog2(T_RESET_DET+1).
- States:
  - SYNC: ignore the line until low_cnt reaches T_RESET_DET, then go to IDLE. Prevents joining mid-frame at power-up or after an error. No outputs pulse.
  - IDLE: line quiet, bit_cnt=0, frame index=0. On rise, go to HIGH.
  - HIGH: on fall, decode bit = (high_cnt >= T_THRESH) and shift it in MSB-first, increment bit_cnt (0..23), then go to LOW. If high_cnt exceeds T_HIGH_MAX before the fall: pulse error, drop the word, go to SYNC.
  - LOW: on rise, go to HIGH (same frame continues). When low_cnt reaches T_RESET_DET:
    - if bit_cnt==0: pulse frame_done, clear the frame index, go to IDLE;
    - if bit_cnt!=0: pulse error (no frame_done), clear bit_cnt and frame index, go to IDLE.
- Word completion:
  - Triggered by the fall that shifts the 24th bit.
  - rgb_data gets the completed word; led_num gets the current frame index; valid pulses for one cycle; bit_cnt returns to 0.
  - The frame index increments and saturates at 255. Further words still emit with led_num=255.
- Latency:
  - Define E as the first clk edge sampling din low after the 24th high pulse. valid is high during the cycle after edge E+2, i.e. 3 clocks after the line falls.
  - frame_done/error follow the same 2-cycle synchronizer skew relative to din.
- Simultaneous events: valid and error can never coincide, since an error aborts before the shift. frame_done fires at least T_RESET_DET cycles after the last valid.
- Boundaries:
  - high_cnt == T_THRESH-1 decodes '0'; high_cnt == T_THRESH decodes '1'.
  - high_cnt == T_HIGH_MAX is legal; T_HIGH_MAX+1 is an error.
  - low_cnt == T_RESET_DET-1 followed by a rise continues the same frame.
- Compatibility: transmitter nominal timing at 12 MHz gives '1' = 10 high / 6 low and '0' = 4 high / 12 low. Both must decode with margin.

Decomposition:
- Shared package ws2812_pkg holds:
  - timing constants derived from CLK_MHZ (T_THRESH, T_HIGH_MAX, T_RESET_DET, plus the transmitter's t_on/t_off/t_period/t_reset) so tx and rx agree;
  - the state encoding enum (SYNC, IDLE, HIGH, LOW);
  - the 24-bit pixel typedef.
- One sub-module, ws2812_rx_sync: 2-FF synchronizer plus edge detect; outputs din_s, rise, fall.

Test Plan:
1. Reset with din held high 1000 cycles, then low 600 cycles, then one 0xFFFFFF word -> no valid during the high period; after the word, valid=1 with rgb_data=0xFFFFFF, led_num=0.
2. From IDLE, send 0xFF0000 then 0x00A55A using transmitter timing, then low 600 cycles -> valid with led_num 0 then 1 and the matching data; frame_done pulses once; next frame restarts at led_num=0.
3. Threshold sweep: single-bit pulses with high 6 vs 7 cycles inside an otherwise known word -> bit decodes 0 vs 1; rgb_data differs only in that bit.
4. Partial word: 10 bits, then low 600 cycles -> error pulses once; no valid and no frame_done; a following full word reports led_num=0.
5. Stuck-high glitch: din high 61 cycles mid-word -> error pulse; decoder ignores traffic until 600 low cycles; the next word decodes correctly with led_num=0.
6. Gap boundary and reset mid-word: low 599 cycles between words 0 and 1 -> still one frame (led_num 0,1, single frame_done). Separately, assert reset after 12 bits -> all outputs 0 and state SYNC.
